// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the machine-mode interrupt/trap controller:
// interrupt codes, CSR addresses, trap instruction encodings and FSM states.
package int_ctrl_pkg;

  localparam logic [31:0] INT_NONE    = 32'h0000_0000;
  localparam logic [31:0] TIME_INT    = 32'h0000_0001;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        WriteEnable = 1'b1;

  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_MEPC       = 3'd1,
    S_MCAUSE     = 3'd2,
    S_MSTATUS    = 3'd3,
    S_ASSERT     = 3'd4,
    S_MRET       = 3'd5,
    S_ASSERT_RET = 3'd6
  } state_e;

  // Trap entry: MPIE takes the old MIE, MIE is cleared.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: MIE takes MPIE back, MPIE is set.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/int_ctrl.sv
// Machine-mode interrupt and synchronous trap sequencer.
// Detects ecall/ebreak/mret in execute and enabled peripheral interrupts,
// writes mepc/mcause/mstatus one per cycle, then redirects the PC.
// Optional build macro: INT_VECTORED_EN enables vectored mtvec mode for
// asynchronous causes; without it the handler is always the direct base.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] CAUSE_TIMER  = 32'h8000_0007,
  parameter logic [31:0] CAUSE_ECALL  = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK = 32'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q,   epc_d;

  logic        is_idle;
  logic        is_ecall;
  logic        is_ebreak;
  logic        is_mret;
  logic        is_async;
  logic        trigger_detected;
  logic [31:0] handler_addr;

  assign is_idle   = (state_q == S_IDLE);
  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign is_async  = (int_flag_i != INT_NONE) && csr_mstatus_i[3];

  assign trigger_detected = is_idle && (is_ecall || is_ebreak || is_mret || is_async);
  assign hold_o           = !is_idle || trigger_detected;

  // Next-state logic: pick the highest-priority trigger while idle and latch
  // its cause/return address, otherwise walk the fixed sequence.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    case (state_q)
      S_IDLE: begin
        if (is_ecall) begin
          state_d = S_MEPC;
          cause_d = CAUSE_ECALL;
          epc_d   = inst_addr_i;
        end else if (is_ebreak) begin
          state_d = S_MEPC;
          cause_d = CAUSE_EBREAK;
          epc_d   = inst_addr_i;
        end else if (is_mret) begin
          state_d = S_MRET;
        end else if (is_async) begin
          state_d = S_MEPC;
          cause_d = (int_flag_i == TIME_INT) ? CAUSE_TIMER : {1'b1, 31'd11};
          epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
        end
      end
      S_MEPC:       state_d = S_MCAUSE;
      S_MCAUSE:     state_d = S_MSTATUS;
      S_MSTATUS:    state_d = S_ASSERT;
      S_ASSERT:     state_d = S_IDLE;
      S_MRET:       state_d = S_ASSERT_RET;
      S_ASSERT_RET: state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // State, cause and return-address registers; reset abandons any sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cause_q <= ZeroWord;
      epc_q   <= ZeroWord;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

`ifdef INT_VECTORED_EN
  // Handler target: vectored offset for asynchronous causes in mode 01.
  always_comb begin
    handler_addr = {csr_mtvec_i[31:2], 2'b00};
    if (csr_mtvec_i[1:0] == 2'b01 && cause_q[31]) begin
      handler_addr = {csr_mtvec_i[31:2], 2'b00} + ({1'b0, cause_q[30:0]} << 2);
    end
  end
`else
  logic unused_mtvec_mode;

  // Handler target: direct mode only, mode bits are don't-care.
  always_comb begin
    handler_addr = {csr_mtvec_i[31:2], 2'b00};
  end

  assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
`endif

  // Moore output decode; CSR inputs are read live in the state that uses them.
  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = 12'h000;
    csr_wdata_o  = ZeroWord;
    int_assert_o = 1'b0;
    int_addr_o   = ZeroWord;
    case (state_q)
      S_MEPC: begin
        csr_we_o    = WriteEnable;
        csr_waddr_o = CSR_MEPC;
        csr_wdata_o = epc_q;
      end
      S_MCAUSE: begin
        csr_we_o    = WriteEnable;
        csr_waddr_o = CSR_MCAUSE;
        csr_wdata_o = cause_q;
      end
      S_MSTATUS: begin
        csr_we_o    = WriteEnable;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = trap_mstatus(csr_mstatus_i);
      end
      S_MRET: begin
        csr_we_o    = WriteEnable;
        csr_waddr_o = CSR_MSTATUS;
        csr_wdata_o = mret_mstatus(csr_mstatus_i);
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = handler_addr;
      end
      S_ASSERT_RET: begin
        int_assert_o = 1'b1;
        int_addr_o   = csr_mepc_i;
      end
      default: begin
        csr_we_o = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Core-side receiver for peripheral interrupt lines such as timer `int_signal_o`, and for synchronous traps (ecall, ebreak, mret).
- Sequences the machine-mode CSR updates (mepc, mcause, mstatus) and redirects the PC to the handler or back to mepc.
- Holds the pipeline while sequencing.
- Sits between execute stage, CSR file and PC control.

Parameters:
- CAUSE_TIMER, 32'h8000_0007, mcause value for the timer interrupt.
- CAUSE_ECALL, 32'd11, mcause value for ecall.
- CAUSE_EBREAK, 32'd3, mcause value for ebreak.

Ports:
- clk  in  1  clock
- rst_n  in  1  async reset, active low
- int_flag_i  in  32  peripheral interrupt code; INT_NONE (0) = none, TIME_INT = timer
- inst_i  in  32  instruction in execute
- inst_addr_i  in  32  PC of inst_i
- jump_flag_i  in  1  execute is redirecting this cycle
- jump_addr_i  in  32  redirect target
- csr_mtvec_i  in  32  current mtvec
- csr_mepc_i  in  32  current mepc
- csr_mstatus_i  in  32  current mstatus
- hold_o  out  1  pipeline hold request
- csr_we_o  out  1  CSR write strobe
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  32  CSR write data
- int_assert_o  out  1  one-cycle PC redirect strobe
- int_addr_o  out  32  redirect target

Behaviour:
- Reset (async, rst_n = 0): state S_IDLE; latched cause/epc = 0; all outputs 0.
- Triggers, evaluated only in S_IDLE, in priority order:
  - ecall: inst_i == 32'h0000_0073
  - ebreak: inst_i == 32'h0010_0073
  - mret: inst_i == 32'h3020_0073
  - async: int_flag_i != 0 && csr_mstatus_i[3] (MIE) == 1
- Sync triggers beat async in the same cycle. The async trigger is not acknowledged; a lost request is re-raised because peripheral pending bits are level until software clears them.
- Latching on the trigger cycle T:
  - sync: epc = inst_addr_i
  - async: epc = jump_flag_i ? jump_addr_i : inst_addr_i
  - cause = CAUSE_ECALL, CAUSE_EBREAK, or CAUSE_TIMER when int_flag_i == TIME_INT (any other nonzero code uses {1'b1, 31'd11}).
- FSM for ecall, ebreak and async: S_IDLE → S_MEPC → S_MCAUSE → S_MSTATUS → S_ASSERT → S_IDLE, one cycle each.
- FSM for mret: S_IDLE → S_MRET → S_ASSERT_RET → S_IDLE.
- Moore outputs per state:
  - S_MEPC: we = 1, addr = 12'h341, data = epc
  - S_MCAUSE: we = 1, addr = 12'h342, data = cause
  - S_MSTATUS: we = 1, addr = 12'h300, data = mstatus with bit7 (MPIE) = old bit3 and bit3 = 0
  - S_MRET: we = 1, addr = 12'h300, data = mstatus with bit3 = old bit7 and bit7 = 1
  - S_ASSERT: int_assert_o = 1, int_addr_o = handler address (see Optional Feature)
  - S_ASSERT_RET: int_assert_o = 1, int_addr_o = csr_mepc_i
  - All other states: we = 0, assert = 0, addr/data = 0.
- Latency: CSR writes in cycles T+1..T+3; redirect in T+4. For mret: write in T+1, redirect in T+2.
- hold_o = (state != S_IDLE) | trigger_detected; combinational, so it is already high in cycle T.
- Triggers arriving while not in S_IDLE are ignored. Inputs are not re-sampled mid-sequence except csr_* (read live in the state that uses them).
- rst_n low mid-sequence: return to S_IDLE immediately, outputs 0; no partial CSR write completes.

Optional Feature:
- Macro: INT_VECTORED_EN.
- Defined: if csr_mtvec_i[1:0] == 2'b01 and the cause is async, int_addr_o = {mtvec[31:2], 2'b00} + (cause[30:0] << 2).
- Defined, other cases: direct mode, int_addr_o = {mtvec[31:2], 2'b00}.
- Undefined: always direct mode; mtvec[1:0] ignored.

Decomposition:
- Shared defines package holds:
  - INT_NONE, TIME_INT
  - ZeroWord, WriteEnable
  - CSR address constants (CSR_MEPC, CSR_MCAUSE, CSR_MSTATUS, CSR_MTVEC)
  - instruction encodings INST_ECALL, INST_EBREAK, INST_MRET
  - FSM state encodings
- No sub-module; single flat module.

Test Plan:
- mstatus = 8, mtvec = 0x100, int_flag_i = TIME_INT, inst_addr_i = 0x40, no jump → T+1 write 0x341 ← 0x40; T+2 0x342 ← 0x8000_0007; T+3 0x300 ← 0x80; T+4 assert, addr 0x100; hold_o high T..T+4.
- Same as above but jump_flag_i = 1, jump_addr_i = 0x80 → mepc written 0x80.
- inst_i = 0x73 at PC 0x20 with int_flag_i = TIME_INT → cause 11, mepc 0x20; timer ignored; after the sequence, with mstatus = 0, no retrigger.
- inst_i = 0x3020_0073, mstatus = 0x80, mepc = 0x44 → T+1 write 0x300 ← 0x88; T+2 assert, addr 0x44.
- mstatus = 0, int_flag_i = TIME_INT → no hold, no writes; rst_n pulsed low during S_MCAUSE → outputs 0 next edge, state idle.
- INT_VECTORED_EN defined, mtvec = 0x101, timer int → int_addr_o = 0x11C; ecall with the same mtvec → 0x100.
